mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Sequences and shares the single memory port between two requesters:
- the CPU controller, via the MREQ_N / R_W_N / ACK handshake;
- a secondary DMA/debug master.

It grants the port with round-robin on conflict, drives a ready-based memory access and bounds it with a timeout. It returns a one-cycle completion pulse so the controller state machine never hangs. The block sits between the controller/datapath and the memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 15, max extra ACCESS cycles waiting for mem_rdy (1..255)
ERR_VAL, 16'hFFFF, read data returned on timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_mreq_n  input  1  CPU request, active low, level
cpu_r_w_n  input  1  1 = read, 0 = write
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_ack  output  1  one-cycle completion pulse to the controller ACK input
dma_req  input  1  DMA request, active high, level
dma_we  input  1  1 = write
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_gnt  output  1  high while a DMA access owns the port
dma_done  output  1  one-cycle completion pulse
rdata  output  DATA_W  registered read data, valid in the ack/done cycle
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  latched address
mem_wdata  output  DATA_W  latched write data; 0 when not writing
mem_rdata  input  DATA_W  memory read data
mem_rdy  input  1  memory ready, sampled each ACCESS cycle
busy  output  1  state != IDLE
bus_err  output  1  one-cycle pulse on timeout (same cycle as ack/done)
err_count  output  8  saturating timeout counter

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE and last_grant = DMA;
  - all outputs to 0, including rdata, err_count and mem_en;
  - mem_en drops immediately, with no clock edge needed.
- Reset mid-access aborts the access. No ack or done is issued.

States: IDLE, ACCESS, RESP.

- IDLE
  - cpu_req = ~cpu_mreq_n.
  - If exactly one requester is active, grant it.
  - If both are active, grant the one that is not last_grant.
  - On grant: latch owner, addr, we (CPU: ~cpu_r_w_n), wdata; clear cnt; update last_grant; go to ACCESS.
  - If neither is active, stay in IDLE.
- ACCESS
  - mem_en = 1; mem_we and mem_addr come from the latched values.
  - mem_wdata = latched wdata when we = 1, otherwise 0.
  - dma_gnt = 1 if owner = DMA.
  - At each edge:
    - if mem_rdy = 1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to RESP with OK status;
    - else if cnt == TIMEOUT: rdata = ERR_VAL (reads only) and go to RESP with ERR status;
    - else cnt++.
  - This gives at most TIMEOUT+1 ACCESS cycles. mem_rdy wins over timeout when both occur in the same cycle.
- RESP (exactly one cycle)
  - mem_en = 0.
  - Pulse cpu_ack or dma_done according to owner.
  - On ERR: bus_err = 1 and err_count++ (saturates at 255).
  - Next state is always IDLE.

Timing and handshake rules:
- Latency: request sampled at edge k gives ACCESS from k+1. With mem_rdy high in the first ACCESS cycle, ack is high in cycle k+2.
- A request still asserted in the IDLE cycle after RESP is treated as a new access. The requester deasserts on seeing ack.
- A request withdrawn during ACCESS does not abort the access; completion is still pulsed.
- Request signals are sampled only in IDLE. Address and data changes during ACCESS are ignored.
- cpu_ack, dma_done and bus_err are never high for more than one consecutive cycle.
- cpu_ack and dma_done are never high together.

Test Plan:
- CPU read: cpu_mreq_n=0, r_w_n=1, addr 0x0040; memory raises rdy on the 3rd ACCESS cycle with 0x1234 -> mem_en high 3 cycles, mem_we=0, then cpu_ack high 1 cycle with rdata=0x1234 and bus_err=0.
- DMA write: dma_req=1, we=1, addr 0x0100, wdata 0xBEEF, rdy immediate -> dma_gnt=1 for 1 cycle with mem_we=1 and mem_wdata=0xBEEF, then dma_done pulse, rdata unchanged.
- Contention: both request continuously after reset -> grants go CPU, DMA, CPU, DMA; each completion pulse goes to the correct requester.
- Timeout: TIMEOUT=15, rdy held low on a CPU read -> 16 ACCESS cycles, then cpu_ack=1, bus_err=1, rdata=0xFFFF, err_count=1. Repeat with rdy asserted exactly in the 16th cycle -> normal completion, bus_err=0.
- Reset mid-access: assert reset during cycle 2 of ACCESS -> mem_en=0 asynchronously, no cpu_ack, busy=0. After release, a new request is served normally.
- Saturation: force 256 timeouts -> err_count holds at 255, and bus_err still pulses on each timeout.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master memory port arbiter with ready handshake and timeout
//
// Shares one memory port between the CPU controller (active-low MREQ_N,
// R_W_N, one-cycle ACK) and a DMA/debug master (active-high req, one-cycle
// done). Contention is resolved round-robin. Each access waits for mem_rdy
// for at most TIMEOUT+1 cycles; after that it completes with ERR_VAL
// returned as read data and a bus_err pulse, so the requester never hangs.
//
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   cpu_mreq_n/r_w_n/addr/wdata   CPU request side
//   cpu_ack                       CPU completion pulse
//   dma_req/we/addr/wdata         DMA request side
//   dma_gnt, dma_done             DMA owns the port / DMA completion pulse
//   rdata                         registered read data, valid with ack/done
//   mem_en/we/addr/wdata          memory strobe, write enable, address, data
//   mem_rdata, mem_rdy            memory read data and ready
//   busy                          arbiter not idle
//   bus_err, err_count            timeout pulse, saturating timeout count
module mem_bus_arbiter #(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter int                TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_VAL = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mreq_n,
  input  logic              cpu_r_w_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              bus_err,
  output logic [7:0]        err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        cnt;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        err_cnt_q;

  logic cpu_req;
  logic any_req;
  logic grant_dma;

  assign cpu_req = ~cpu_mreq_n;
  assign any_req = cpu_req | dma_req;
  // DMA wins when it is alone, or when both ask and the CPU was served last.
  assign grant_dma = dma_req & (~cpu_req | (last_grant == OWN_CPU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= OWN_CPU;
      last_grant <= OWN_DMA;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner      <= grant_dma;
            last_grant <= grant_dma;
            addr_q     <= grant_dma ? dma_addr  : cpu_addr;
            wdata_q    <= grant_dma ? dma_wdata : cpu_wdata;
            we_q       <= grant_dma ? dma_we    : ~cpu_r_w_n;
            cnt        <= '0;
            err_q      <= 1'b0;
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Ready takes priority over the timeout in the same cycle.
          if (mem_rdy) begin
            if (!we_q) rdata_q <= mem_rdata;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (cnt == TO_LIMIT) begin
            if (!we_q) rdata_q <= ERR_VAL;
            err_q <= 1'b1;
            // Counted on entry to RESP so the new value is visible with bus_err.
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // All port-facing strobes decode from the state register, so an async
  // reset drops mem_en immediately and a RESP cycle always yields one pulse.
  assign mem_en    = (state == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = (mem_en & we_q) ? wdata_q : '0;
  assign dma_gnt   = mem_en & (owner == OWN_DMA);
  assign cpu_ack   = (state == S_RESP) & (owner == OWN_CPU);
  assign dma_done  = (state == S_RESP) & (owner == OWN_DMA);
  assign bus_err   = (state == S_RESP) & err_q;
  assign busy      = (state != S_IDLE);
  assign rdata     = rdata_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mreq_n, cpu_r_w_n;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rdy;
  logic        busy, bus_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  logic prev_ack = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_mreq_n(cpu_mreq_n), .cpu_r_w_n(cpu_r_w_n), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .busy(busy), .bus_err(bus_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Pulse-shape rules observed across the whole run.
  always @(negedge clk) begin
    if (!reset) begin
      if ((cpu_ack && dma_done) || (cpu_ack && prev_ack) ||
          (dma_done && prev_done) || (bus_err && prev_err))
        viol <= viol + 1;
    end
    prev_ack  <= cpu_ack;
    prev_done <= dma_done;
    prev_err  <= bus_err;
  end

  typedef struct {
    logic        mreq_n, rw_n, dreq, dwe, rdy;
    logic [15:0] mrd;
    logic        en, we, ack, done, gnt, busy;
    logic [15:0] addr, wd, rd;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CPU read with the request withdrawn after the grant; mem_rdy is raised
  // only during ACCESS cycle rdy_cycle (0 = never).
  task automatic cpu_read(input int rdy_cycle, output int ncyc, output logic saw_ack,
                          output logic saw_err, output logic [15:0] rd, output logic [7:0] ec);
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b1; mem_rdy = 1'b0;
    step();
    cpu_mreq_n = 1'b1;
    ncyc = 0; saw_ack = 1'b0; saw_err = 1'b0; rd = '0; ec = '0;
    for (int c = 1; c <= 40; c++) begin
      if (!saw_ack) begin
        if (mem_en) ncyc++;
        mem_rdy = (c == rdy_cycle);
        step();
        if (cpu_ack) begin
          saw_ack = 1'b1; saw_err = bus_err; rd = rdata; ec = err_count;
        end
      end
    end
    mem_rdy = 1'b0;
    step();
  endtask

  initial begin
    int          ncyc, misses;
    logic        ack, err, seen_ack;
    logic [15:0] rd;
    logic [7:0]  ec;

    reset = 1'b1;
    cpu_mreq_n = 1'b1; cpu_r_w_n = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h5555;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0100; dma_wdata = 16'hBEEF;
    mem_rdata = 16'h0000; mem_rdy = 1'b0;

    //            mreq rw dreq dwe rdy  mrd       en we ack dn gnt bsy addr      wd        rd
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h0040,16'h0000,16'h0000};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,16'h1234, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 16'h0040,16'h0000,16'h1234};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0040,16'h0000,16'h1234};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,16'h0000, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 16'h0100,16'hBEEF,16'h1234};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 16'h0100,16'h0000,16'h1234};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0100,16'h0000,16'h1234};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,16'hAAAA, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h0040,16'h0000,16'h1234};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,16'hAAAA, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 16'h0040,16'h0000,16'hAAAA};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b1,1'b1,16'hAAAA, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0040,16'h0000,16'hAAAA};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b1,16'hAAAA, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 16'h0100,16'hBEEF,16'hAAAA};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b1,1'b1,16'hAAAA, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 16'h0100,16'h0000,16'hAAAA};
    tbl[13] = tbl[10];
    tbl[14] = tbl[8];
    tbl[14].rd = 16'hAAAA;
    tbl[15] = tbl[9];
    tbl[16] = tbl[10];
    tbl[17] = tbl[11];
    tbl[18] = tbl[12];
    tbl[19] = '{1'b1,1'b1,1'b0,1'b0,1'b0,16'hAAAA, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0100,16'h0000,16'hAAAA};

    // Reset state
    step(); step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {cpu_ack, dma_done, dma_gnt, bus_err, mem_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;

    // Table: CPU read (rdy on 3rd ACCESS cycle), DMA write, contention
    for (int i = 0; i < 20; i++) begin
      cpu_mreq_n = tbl[i].mreq_n; cpu_r_w_n = tbl[i].rw_n;
      dma_req = tbl[i].dreq; dma_we = tbl[i].dwe;
      mem_rdy = tbl[i].rdy; mem_rdata = tbl[i].mrd;
      step();
      chk($sformatf("v%0d_mem_en", i), mem_en, tbl[i].en);
      chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d_cpu_ack", i), cpu_ack, tbl[i].ack);
      chk($sformatf("v%0d_dma_done", i), dma_done, tbl[i].done);
      chk($sformatf("v%0d_dma_gnt", i), dma_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_bus_err", i), bus_err, 0);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
      if (tbl[i].en) chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
    end
    cpu_mreq_n = 1'b1; dma_req = 1'b0; mem_rdy = 1'b0;
    step();

    // Timeout: 16 ACCESS cycles then ack with error
    mem_rdata = 16'h5A5A;
    cpu_read(0, ncyc, ack, err, rd, ec);
    chk("to_ack", ack, 1);
    chk("to_cycles", ncyc, 16);
    chk("to_bus_err", err, 1);
    chk("to_rdata", rd, 16'hFFFF);
    chk("to_err_count", ec, 1);

    // Ready in the 16th cycle wins over the timeout
    cpu_read(16, ncyc, ack, err, rd, ec);
    chk("late_ack", ack, 1);
    chk("late_cycles", ncyc, 16);
    chk("late_bus_err", err, 0);
    chk("late_rdata", rd, 16'h5A5A);
    chk("late_err_count", ec, 1);

    // Reset during ACCESS cycle 2
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b1; mem_rdy = 1'b0;
    step();
    cpu_mreq_n = 1'b1;
    step();
    chk("mid_in_access", mem_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_mem_en_async", mem_en, 0);
    chk("mid_busy", busy, 0);
    seen_ack = cpu_ack;
    step(); seen_ack |= cpu_ack;
    step(); seen_ack |= cpu_ack;
    chk("mid_no_ack", seen_ack, 0);
    chk("mid_err_count", err_count, 0);
    reset = 1'b0;
    step(); seen_ack |= cpu_ack;
    chk("mid_no_ack_after", seen_ack, 0);

    // New CPU write after reset
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b0; mem_rdy = 1'b1;
    step();
    chk("post_mem_we", mem_we, 1);
    chk("post_mem_wdata", mem_wdata, 16'h5555);
    chk("post_mem_addr", mem_addr, 16'h0040);
    cpu_mreq_n = 1'b1;
    step();
    chk("post_ack", cpu_ack, 1);
    chk("post_bus_err", bus_err, 0);
    chk("post_rdata", rdata, 0);
    mem_rdy = 1'b0;
    step();

    // Saturation: 256 timeouts
    misses = 0;
    for (int n = 0; n < 256; n++) begin
      cpu_read(0, ncyc, ack, err, rd, ec);
      if (!ack || !err) misses++;
    end
    chk("sat_err_pulses", misses, 0);
    chk("sat_err_count", err_count, 255);
    chk("sat_last_ec", ec, 255);

    chk("pulse_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
